caliptra_apb_arbiter: RTL
=========================

Name: caliptra_apb_arbiter

Overview:
- Two-requester APB arbiter that shares the single Caliptra wrapper APB slave port (PADDR/PSEL/PENABLE/...) between two APB masters, e.g. host PS APB and an on-fabric mailbox sequencer.
- Sits between the masters and the Caliptra wrapper APB inputs in the FPGA package top.
- Round-robin grant with a registered, fully APB-compliant SETUP/ACCESS sequence on the slave side.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- USER_WIDTH, 32, PAUSER width.
- TIMEOUT_CYCLES, 1024, ACCESS-phase watchdog limit. Used only with the optional feature; must be ≥2.

Ports:
- core_clk  input  1  sole clock.
- core_rst  input  1  reset, synchronous, active-high.
- mN_psel / mN_penable / mN_pwrite  input  1 each  master N (N=0,1) APB controls.
- mN_paddr  input  ADDR_WIDTH  master N address.
- mN_pwdata  input  DATA_WIDTH  master N write data.
- mN_pprot  input  3  master N protection.
- mN_pauser  input  USER_WIDTH  master N PAUSER.
- mN_prdata  output  DATA_WIDTH  read data to master N.
- mN_pready  output  1  transfer complete to master N.
- mN_pslverr  output  1  error to master N.
- s_psel / s_penable / s_pwrite  output  1 each  to the Caliptra APB slave.
- s_paddr / s_pwdata / s_pprot / s_pauser  output  ADDR_WIDTH/DATA_WIDTH/3/USER_WIDTH  to slave.
- s_prdata  input  DATA_WIDTH  slave read data.
- s_pready / s_pslverr  input  1 each  slave handshake.
- grant  output  2  one-hot owner of the current transfer; 0 in IDLE.
- timeout_evt  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; last_grant=1, so m0 wins the first tie. Reset mid-transfer aborts the transfer. s_psel/s_penable are 0 the cycle after core_rst is sampled. No mN_pready is issued for the aborted transfer.
- Request: reqN = mN_psel. mN_penable is not used for arbitration.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that master.
- IDLE, both requesting: grant the master ≠ last_grant. Set last_grant to the winner.
- IDLE, on grant: capture winner's paddr/pwrite/pwdata/pprot/pauser into slave-side registers; go to SETUP.
- SETUP: s_psel=1, s_penable=0; go to ACCESS.
- ACCESS: s_psel=1, s_penable=1.
  - On s_pready=1: capture s_prdata (forced 0 on writes) and s_pslverr; go to DONE.
  - Otherwise stay in ACCESS.
- DONE: s_psel=s_penable=0. Granted master sees mN_pready=1 for exactly one cycle with captured prdata/pslverr. Go to IDLE.
- Non-granted master: mN_pready=mN_pslverr=0 and mN_prdata=0 at all times; it stalls in its access phase.
- mN_prdata/mN_pslverr are 0 whenever mN_pready=0.
- Minimum latency, zero-wait slave: psel seen in cycle 0 → SETUP c1 → ACCESS c2 → mN_pready in c3.
- Back-to-back: a master re-asserting psel in the cycle after DONE is arbitrated normally. With both masters continuously requesting, grants strictly alternate 0,1,0,1.
- A master dropping psel while stalled (protocol violation) does not disturb an in-flight transfer. If the slave transfer was already issued, it completes on the slave side and the result is discarded.
- grant: one-hot from SETUP through DONE inclusive, else 0.
- Slave-side signals are stable from SETUP until the transfer leaves ACCESS.

Optional Feature:
- Macro: CALIPTRA_APB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with s_pready=0.
  - When it reaches TIMEOUT_CYCLES: go to DONE with prdata=0, pslverr=1; drop s_psel/s_penable; pulse timeout_evt for 1 cycle.
  - s_pready arriving in the same cycle as expiry wins: normal completion, no timeout_evt.
- When undefined: ACCESS waits indefinitely; timeout_evt tied 0; no counter logic.

Test Plan:
- Single read, m0: paddr=0x30030000, slave returns 0xDEADBEEF with zero wait → s_psel c1, s_penable c2, m0_pready=1 c3 with m0_prdata=0xDEADBEEF, pslverr=0, grant=01 for c1–c3.
- Write, m1: pwdata=0x12345678, pauser=0xFFFFFFFF, slave holds s_pready=0 for 5 ACCESS cycles → s_pwdata/s_pauser stable throughout; m1_pready 1 cycle after s_pready; m1_prdata=0.
- Contention from reset: both psel in the same cycle → m0 granted first, m1 next; 4 continuous back-to-back requests each → grant order 0,1,0,1,0,1,0,1.
- Slave error: s_pslverr=1 with s_pready → granted master pslverr=1 with pready; other master pready stays 0.
- Reset mid-ACCESS: assert core_rst while s_penable=1 → next cycle s_psel=s_penable=0, grant=0, no mN_pready. First transfer after reset grants m0 on a tie.
- With CALIPTRA_APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: slave never readies → timeout_evt pulse after 16 ACCESS cycles, master pready=1 with pslverr=1, prdata=0. Without the macro: still waiting at cycle 1000.

Source files
------------

// File: rtl/caliptra_apb_arbiter.sv
// caliptra_apb_arbiter: round-robin two-master APB arbiter onto the Caliptra wrapper slave port.
// Optional ACCESS-phase watchdog enabled by defining CALIPTRA_APB_ARB_TIMEOUT_EN.
module caliptra_apb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int USER_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic [DATA_WIDTH-1:0] m0_pwdata,
    input  logic [2:0]            m0_pprot,
    input  logic [USER_WIDTH-1:0] m0_pauser,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    output logic                  m0_pready,
    output logic                  m0_pslverr,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0] m1_pwdata,
    input  logic [2:0]            m1_pprot,
    input  logic [USER_WIDTH-1:0] m1_pauser,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  m1_pready,
    output logic                  m1_pslverr,
    output logic                  s_psel,
    output logic                  s_penable,
    output logic                  s_pwrite,
    output logic [ADDR_WIDTH-1:0] s_paddr,
    output logic [DATA_WIDTH-1:0] s_pwdata,
    output logic [2:0]            s_pprot,
    output logic [USER_WIDTH-1:0] s_pauser,
    input  logic [DATA_WIDTH-1:0] s_prdata,
    input  logic                  s_pready,
    input  logic                  s_pslverr,
    output logic [1:0]            grant,
    output logic                  timeout_evt
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic                  win1;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            prot_q, prot_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  err_q, err_d;
    logic                  unused_ok;

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tevt_q, tevt_d;
    assign unused_ok   = m0_penable ^ m1_penable;
    assign timeout_evt = tevt_q;
`else
    assign unused_ok   = ^{m0_penable, m1_penable, 32'(TIMEOUT_CYCLES)};
    assign timeout_evt = 1'b0;
`endif

    // m1 wins when it is the only requester, or on a tie when m0 owned the last transfer
    assign win1 = m1_psel & (~m0_psel | ~last_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        prot_d  = prot_q;
        user_d  = user_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tevt_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_psel | m1_psel) begin
                    state_d = SETUP;
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    last_d  = win1;
                    addr_d  = win1 ? m1_paddr  : m0_paddr;
                    write_d = win1 ? m1_pwrite : m0_pwrite;
                    wdata_d = win1 ? m1_pwdata : m0_pwdata;
                    prot_d  = win1 ? m1_pprot  : m0_pprot;
                    user_d  = win1 ? m1_pauser : m0_pauser;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (s_pready) begin
                    state_d = DONE;
                    rdata_d = write_q ? '0 : s_prdata;
                    err_d   = s_pslverr;
                end
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tevt_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            prot_q  <= '0;
            user_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tevt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            prot_q  <= prot_d;
            user_q  <= user_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tevt_q  <= tevt_d;
`endif
        end
    end

    assign s_psel    = (state_q == SETUP) | (state_q == ACCESS);
    assign s_penable = state_q == ACCESS;
    assign s_paddr   = addr_q;
    assign s_pwrite  = write_q;
    assign s_pwdata  = wdata_q;
    assign s_pprot   = prot_q;
    assign s_pauser  = user_q;
    assign grant     = (state_q == IDLE) ? 2'b00 : gnt_q;

    // responses are only visible to the owner, and only during DONE
    assign m0_pready  = (state_q == DONE) & gnt_q[0];
    assign m1_pready  = (state_q == DONE) & gnt_q[1];
    assign m0_prdata  = m0_pready ? rdata_q : '0;
    assign m1_prdata  = m1_pready ? rdata_q : '0;
    assign m0_pslverr = m0_pready & err_q;
    assign m1_pslverr = m1_pready & err_q;

endmodule
